// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serialises instruction-fetch and LSU requests
// into per-byte accesses on an 8-bit RAM, data channel taking priority.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instEn,
    input  logic [ADDR_W-1:0] instAddr,
    output logic              memInstFree,
    output logic              memInstOutEn,
    output logic [31:0]       memInst,
    input  logic              dataEn,
    input  logic              dataWr,
    input  logic [1:0]        dataLen,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [31:0]       dataIn,
    output logic              memDataFree,
    output logic              memDataOutEn,
    output logic [31:0]       memData,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE, INST_RD, DATA_RD, DATA_WR} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          n_q, n_d;
    logic [31:0]         asm_q, asm_d;
    logic                inst_pend_q, inst_pend_d;
    logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
    logic                data_pend_q, data_pend_d;
    logic                data_wr_q, data_wr_d;
    logic [1:0]          data_len_q, data_len_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [31:0]         data_in_q, data_in_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_wr_q, ram_wr_d;
    logic [7:0]          ram_dout_q, ram_dout_d;
    logic [31:0]         mem_inst_q, mem_inst_d;
    logic [31:0]         mem_data_q, mem_data_d;
    logic                inst_out_en_q, inst_out_en_d;
    logic                data_out_en_q, data_out_en_d;
    logic [1:0]          rd_lane;
    logic [1:0]          wr_lane;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // RAM returns the previously addressed byte, so byte k arrives when cnt_q = k+1.
    assign rd_lane = 2'(cnt_q - 3'd1);
    assign wr_lane = 2'(cnt_q + 3'd1);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        cnt_d         = cnt_q;
        n_d           = n_q;
        asm_d         = asm_q;
        inst_pend_d   = inst_pend_q;
        inst_addr_d   = inst_addr_q;
        data_pend_d   = data_pend_q;
        data_wr_d     = data_wr_q;
        data_len_d    = data_len_q;
        data_addr_d   = data_addr_q;
        data_in_d     = data_in_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_d      = 1'b0;
        ram_dout_d    = ram_dout_q;
        mem_inst_d    = mem_inst_q;
        mem_data_d    = mem_data_q;
        inst_out_en_d = 1'b0;
        data_out_en_d = 1'b0;

        // A request on a busy channel is a protocol violation and is dropped.
        if (instEn && !inst_pend_q) begin
            inst_pend_d = 1'b1;
            inst_addr_d = instAddr;
        end
        if (dataEn && !data_pend_q) begin
            data_pend_d = 1'b1;
            data_wr_d   = dataWr;
            data_len_d  = dataLen;
            data_addr_d = dataAddr;
            data_in_d   = dataIn;
        end

        if ((state_q == INST_RD || state_q == DATA_RD) && cnt_q != 3'd0) begin
            asm_d[{rd_lane, 3'b000} +: 8] = ram_din;
        end

        unique case (state_q)
            IDLE: begin
                if (data_pend_d) begin
                    state_d    = data_wr_d ? DATA_WR : DATA_RD;
                    n_d        = len_to_n(data_len_d);
                    cnt_d      = 3'd0;
                    asm_d      = '0;
                    ram_addr_d = data_addr_d;
                    ram_wr_d   = data_wr_d;
                    ram_dout_d = data_in_d[7:0];
                end else if (inst_pend_d) begin
                    state_d    = INST_RD;
                    n_d        = 3'd4;
                    cnt_d      = 3'd0;
                    asm_d      = '0;
                    ram_addr_d = inst_addr_d;
                end
            end

            INST_RD, DATA_RD: begin
                cnt_d = 3'(cnt_q + 3'd1);
                if (3'(cnt_q + 3'd1) < n_q) begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                end
                if (cnt_q == n_q) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == INST_RD) begin
                        mem_inst_d    = asm_d;
                        inst_out_en_d = 1'b1;
                        inst_pend_d   = 1'b0;
                    end else begin
                        mem_data_d    = asm_d;
                        data_out_en_d = 1'b1;
                        data_pend_d   = 1'b0;
                    end
                end
            end

            DATA_WR: begin
                if (3'(cnt_q + 3'd1) < n_q) begin
                    cnt_d      = 3'(cnt_q + 3'd1);
                    ram_wr_d   = 1'b1;
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    ram_dout_d = data_in_q[{wr_lane, 3'b000} +: 8];
                end else begin
                    state_d       = IDLE;
                    cnt_d         = 3'd0;
                    data_out_en_d = 1'b1;
                    data_pend_d   = 1'b0;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            n_q           <= '0;
            asm_q         <= '0;
            inst_pend_q   <= 1'b0;
            inst_addr_q   <= '0;
            data_pend_q   <= 1'b0;
            data_wr_q     <= 1'b0;
            data_len_q    <= '0;
            data_addr_q   <= '0;
            data_in_q     <= '0;
            ram_addr_q    <= '0;
            ram_wr_q      <= 1'b0;
            ram_dout_q    <= '0;
            mem_inst_q    <= '0;
            mem_data_q    <= '0;
            inst_out_en_q <= 1'b0;
            data_out_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            n_q           <= n_d;
            asm_q         <= asm_d;
            inst_pend_q   <= inst_pend_d;
            inst_addr_q   <= inst_addr_d;
            data_pend_q   <= data_pend_d;
            data_wr_q     <= data_wr_d;
            data_len_q    <= data_len_d;
            data_addr_q   <= data_addr_d;
            data_in_q     <= data_in_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_q      <= ram_wr_d;
            ram_dout_q    <= ram_dout_d;
            mem_inst_q    <= mem_inst_d;
            mem_data_q    <= mem_data_d;
            inst_out_en_q <= inst_out_en_d;
            data_out_en_q <= data_out_en_d;
        end
    end

    assign memInstFree  = !inst_pend_q;
    assign memDataFree  = !data_pend_q;
    assign memInstOutEn = inst_out_en_q;
    assign memDataOutEn = data_out_en_q;
    assign memInst      = mem_inst_q;
    assign memData      = mem_data_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wr       = ram_wr_q;
    assign ram_dout     = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte-wide RAM with one-cycle read latency,
// a table of single requests and hand-written multi-cycle corner cases.
module tb_mem_ctrl;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              instEn;
    logic [ADDR_W-1:0] instAddr;
    logic              memInstFree;
    logic              memInstOutEn;
    logic [31:0]       memInst;
    logic              dataEn;
    logic              dataWr;
    logic [1:0]        dataLen;
    logic [ADDR_W-1:0] dataAddr;
    logic [31:0]       dataIn;
    logic              memDataFree;
    logic              memDataOutEn;
    logic [31:0]       memData;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instEn      (instEn),
        .instAddr    (instAddr),
        .memInstFree (memInstFree),
        .memInstOutEn(memInstOutEn),
        .memInst     (memInst),
        .dataEn      (dataEn),
        .dataWr      (dataWr),
        .dataLen     (dataLen),
        .dataAddr    (dataAddr),
        .dataIn      (dataIn),
        .memDataFree (memDataFree),
        .memDataOutEn(memDataOutEn),
        .memData     (memData),
        .ram_addr    (ram_addr),
        .ram_wr      (ram_wr),
        .ram_dout    (ram_dout),
        .ram_din     (ram_din)
    );

    always #5 clk = ~clk;

    // RAM: low 12 address bits select the byte; read data lags the address by one cycle.
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        ram_din <= mem[ram_addr[11:0]];
        if (ram_wr) mem[ram_addr[11:0]] <= ram_dout;
    end

    typedef struct {
        string       name;
        bit          inst;
        bit          wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nbytes;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] last_data = 32'h0;
    vec_t        vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        instEn   = 1'b0;
        dataEn   = 1'b0;
        dataWr   = 1'b0;
        dataLen  = 2'b00;
        instAddr = '0;
        dataAddr = '0;
        dataIn   = '0;
    endtask

    task automatic run_vec(input vec_t v);
        logic        free, pulse, other;
        logic [31:0] data, ea;
        @(negedge clk);
        check({v.name, " free before"}, v.inst ? memInstFree : memDataFree, 1'b1);
        if (v.inst) begin
            instEn   = 1'b1;
            instAddr = v.addr;
        end else begin
            dataEn   = 1'b1;
            dataWr   = v.wr;
            dataLen  = v.len;
            dataAddr = v.addr;
            dataIn   = v.wdata;
        end
        for (int k = 1; k <= v.lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) idle_inputs();
            free  = v.inst ? memInstFree  : memDataFree;
            pulse = v.inst ? memInstOutEn : memDataOutEn;
            other = v.inst ? memDataOutEn : memInstOutEn;
            data  = v.inst ? memInst      : memData;
            check($sformatf("%s outen c%0d", v.name, k), pulse, (k == v.lat) ? 1'b1 : 1'b0);
            check($sformatf("%s other outen c%0d", v.name, k), other, 1'b0);
            if (k <= v.lat) check($sformatf("%s free c%0d", v.name, k), free, (k == v.lat) ? 1'b1 : 1'b0);
            if (k <= v.nbytes) begin
                ea = v.addr + 32'(k - 1);
                check($sformatf("%s ram_addr c%0d", v.name, k), ram_addr, ea);
                check($sformatf("%s ram_wr c%0d", v.name, k), ram_wr, v.wr);
                if (v.wr) check($sformatf("%s ram_dout c%0d", v.name, k), ram_dout, v.wdata[8*(k-1) +: 8]);
            end else if (k == v.nbytes + 1) begin
                check($sformatf("%s ram_wr end", v.name), ram_wr, 1'b0);
                if (!v.wr) check($sformatf("%s ram_addr hold", v.name), ram_addr, v.addr + 32'(v.nbytes - 1));
            end
            if (k >= v.lat) check($sformatf("%s data c%0d", v.name, k), data, v.wr ? last_data : v.exp);
        end
        if (v.wr) begin
            for (int j = 0; j < v.nbytes; j++) begin
                ea = v.addr + 32'(j);
                check($sformatf("%s ram byte %0d", v.name, j), {24'h0, mem[ea[11:0]]}, {24'h0, v.wdata[8*j +: 8]});
            end
            ea = v.addr + 32'(v.nbytes);
            check({v.name, " ram untouched"}, {24'h0, mem[ea[11:0]]}, 32'h5A);
        end else if (!v.inst) begin
            last_data = v.exp;
        end
    endtask

    int          d_at, d_cnt, i_at, i_cnt;
    logic [31:0] d_val, i_val;
    int          pulse_at [2];
    logic [31:0] pulse_val [2];
    int          pcnt;
    bit          any_wr, bad_pulse;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        mem[12'h100] <= 8'h13; mem[12'h101] <= 8'h05; mem[12'h102] <= 8'h10; mem[12'h103] <= 8'h00;
        mem[12'h206] <= 8'h5A;
        mem[12'h300] <= 8'h80; mem[12'h301] <= 8'h34; mem[12'h302] <= 8'h12;
        mem[12'hFFE] <= 8'h11; mem[12'hFFF] <= 8'h22; mem[12'h000] <= 8'h33; mem[12'h001] <= 8'h44;
        mem[12'h400] <= 8'hEF; mem[12'h401] <= 8'hBE; mem[12'h402] <= 8'hAD; mem[12'h403] <= 8'hDE;
        mem[12'h504] <= 8'h5A; mem[12'h601] <= 8'h5A; mem[12'h700] <= 8'h5A; mem[12'h803] <= 8'h5A;

        //          name          inst wr  len    addr          wdata         N  lat exp
        vecs[0] = '{"inst_rd",    1, 0, 2'b10, 32'h0000_0100, 32'h0,        4, 6, 32'h0010_0513};
        vecs[1] = '{"half_wr",    0, 1, 2'b01, 32'h0000_0204, 32'h1234_BEEF, 2, 3, 32'h0};
        vecs[2] = '{"byte_rd",    0, 0, 2'b00, 32'h0000_0300, 32'h0,        1, 3, 32'h0000_0080};
        vecs[3] = '{"wrap_rd",    0, 0, 2'b10, 32'hFFFF_FFFE, 32'h0,        4, 6, 32'h4433_2211};
        vecs[4] = '{"half_rd",    0, 0, 2'b01, 32'h0000_0301, 32'h0,        2, 4, 32'h0000_1234};
        vecs[5] = '{"word_wr",    0, 1, 2'b11, 32'h0000_0500, 32'hCAFE_F00D, 4, 5, 32'h0};
        vecs[6] = '{"byte_wr",    0, 1, 2'b00, 32'h0000_0600, 32'hAABB_CC77, 1, 2, 32'h0};
        vecs[7] = '{"word_rdback",0, 0, 2'b10, 32'h0000_0500, 32'h0,        4, 6, 32'hCAFE_F00D};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst memInstFree", memInstFree, 1'b1);
        check("rst memDataFree", memDataFree, 1'b1);
        check("rst memInstOutEn", memInstOutEn, 1'b0);
        check("rst memDataOutEn", memDataOutEn, 1'b0);
        check("rst memInst", memInst, 32'h0);
        check("rst memData", memData, 32'h0);
        check("rst ram_addr", ram_addr, 32'h0);
        check("rst ram_wr", ram_wr, 1'b0);
        check("rst ram_dout", ram_dout, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Simultaneous requests: data word read served first, instruction right after.
        @(negedge clk);
        instEn = 1'b1; instAddr = 32'h100;
        dataEn = 1'b1; dataWr = 1'b0; dataLen = 2'b10; dataAddr = 32'h400;
        d_at = 0; d_cnt = 0; i_at = 0; i_cnt = 0; d_val = '0; i_val = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) idle_inputs();
            if (memDataOutEn) begin if (d_cnt == 0) d_at = k; d_cnt++; d_val = memData; end
            if (memInstOutEn) begin if (i_cnt == 0) i_at = k; i_cnt++; i_val = memInst; end
            if (k == 11) check("sim inst free c11", memInstFree, 1'b0);
            if (k == 12) check("sim inst free c12", memInstFree, 1'b1);
        end
        check("sim data pulse cycle", d_at, 6);
        check("sim data pulse count", d_cnt, 1);
        check("sim data value", d_val, 32'hDEAD_BEEF);
        check("sim inst pulse cycle", i_at, 12);
        check("sim inst pulse count", i_cnt, 1);
        check("sim inst value", i_val, 32'h0010_0513);

        // Ignored request while busy, then back-to-back request in the pulse cycle.
        @(negedge clk);
        dataEn = 1'b1; dataWr = 1'b0; dataLen = 2'b00; dataAddr = 32'h300;
        pcnt = 0; any_wr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            idle_inputs();
            if (ram_wr) any_wr = 1'b1;
            if (memDataOutEn) begin
                if (pcnt < 2) begin pulse_at[pcnt] = k; pulse_val[pcnt] = memData; end
                pcnt++;
            end
            if (k == 1) begin
                dataEn = 1'b1; dataWr = 1'b1; dataLen = 2'b00; dataAddr = 32'h700; dataIn = 32'h99;
            end
            if (k == 3) begin
                check("b2b free in pulse cycle", memDataFree, 1'b1);
                dataEn = 1'b1; dataWr = 1'b0; dataLen = 2'b00; dataAddr = 32'h301;
            end
        end
        check("b2b pulse count", pcnt, 2);
        check("b2b first pulse cycle", pulse_at[0], 3);
        check("b2b first value", pulse_val[0], 32'h80);
        check("b2b second pulse cycle", pulse_at[1], 6);
        check("b2b second value", pulse_val[1], 32'h34);
        check("ignored write no ram_wr", any_wr, 1'b0);
        check("ignored write ram", {24'h0, mem[12'h700]}, 32'h5A);

        // Reset asserted in Tr+3 of a word write aborts it.
        @(negedge clk);
        dataEn = 1'b1; dataWr = 1'b1; dataLen = 2'b10; dataAddr = 32'h800; dataIn = 32'h1122_3344;
        bad_pulse = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) idle_inputs();
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                check("abort ram_wr", ram_wr, 1'b0);
                check("abort memDataOutEn", memDataOutEn, 1'b0);
                check("abort memInstFree", memInstFree, 1'b1);
                check("abort memDataFree", memDataFree, 1'b1);
                check("abort memData", memData, 32'h0);
                rst = 1'b0;
            end
            if (k > 4 && (memDataOutEn || memInstOutEn || ram_wr)) bad_pulse = 1'b1;
        end
        check("abort no later activity", bad_pulse, 1'b0);
        check("abort byte0", {24'h0, mem[12'h800]}, 32'h44);
        check("abort byte2", {24'h0, mem[12'h802]}, 32'h22);
        check("abort byte3 untouched", {24'h0, mem[12'h803]}, 32'h5A);
        last_data = 32'h0;
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Byte-serial memory controller between the 8-bit unified RAM and the instruction-fetch and load/store stages. It accepts one-cycle request pulses from fetch (word instruction reads) and from the LSU (byte/half/word reads and writes). It serialises each request into per-byte RAM accesses and returns assembled little-endian data with a one-cycle valid pulse. Data requests take priority over instruction requests; a losing request is held pending, not dropped.

Parameters:
ADDR_W, 32, width of all byte addresses; increments wrap modulo 2^ADDR_W.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
instEn  in  1  instruction read request pulse
instAddr  in  ADDR_W  instruction byte address
memInstFree  out  1  high when no instruction request is pending or in progress
memInstOutEn  out  1  one-cycle pulse; memInst valid
memInst  out  32  assembled instruction
dataEn  in  1  data request pulse
dataWr  in  1  1 = write, 0 = read (sampled with dataEn)
dataLen  in  2  00 byte, 01 half, 10/11 word
dataAddr  in  ADDR_W  data byte address
dataIn  in  32  write data; low bytes used
memDataFree  out  1  high when no data request is pending or in progress
memDataOutEn  out  1  one-cycle pulse; read data valid or write done
memData  out  32  read data, zero-extended (LSU sign-extends)
ram_addr  out  ADDR_W  RAM byte address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  byte to RAM
ram_din  in  8  byte from RAM; returns the byte addressed in the previous cycle

Behaviour:
- Reset values: memInstFree=1, memDataFree=1, memInstOutEn=0, memDataOutEn=0, memInst=0, memData=0, ram_addr=0, ram_wr=0, ram_dout=0. The state goes to IDLE and both pending latches clear.
- Reset during an operation aborts it. No OutEn pulse is issued. ram_wr is 0 from the cycle after the reset edge.
- Requests are captured into pending latches at the edge ending the request cycle Tr. Free drops in Tr+1.
- A request on a channel whose Free is 0 is a protocol violation and is ignored.
- States: IDLE, INST_RD, DATA_RD, DATA_WR. N = 4 for instructions; for data, N = 1/2/4 per dataLen.
- From IDLE: a pending data request enters DATA_RD/DATA_WR; otherwise a pending instruction request enters INST_RD. The new state is active in Tr+1 = T0.
- Read, cycles T0..T0+N-1: ram_addr = base+k, ram_wr = 0.
- Read capture: ram_din in cycle T0+k+1 is captured as byte k, into bits [8k+7:8k].
- Read, cycle T0+N: ram_addr holds, ram_wr = 0, and the last byte is captured.
- Read completion, cycle T0+N+1: OutEn = 1 for one cycle; data is stable and unused high bytes are 0. Free = 1 and the state is IDLE.
- Read latency: instruction word = Tr+6; data byte = Tr+3.
- Write, cycles T0..T0+N-1: ram_wr = 1, ram_addr = base+k, ram_dout = dataIn[8k+7:8k].
- Write completion, cycle T0+N: ram_wr = 0, memDataOutEn pulse, memDataFree = 1, state IDLE. memData is unchanged.
- Output hold: memInst and memData hold their values between pulses.
- Back-to-back: a request is accepted in the pulse cycle or any later IDLE cycle.
- On completion, if the other channel is pending, its operation starts in the cycle after the pulse.
- Simultaneous instEn and dataEn in one cycle: the data operation is served first and the instruction operation immediately after.
- Address wrap: base+k is computed modulo 2^ADDR_W.

Test Plan:
- Instruction read: RAM[0x100..0x103] = 13,05,10,00; instEn with 0x100 at Tr -> memInstOutEn only at Tr+6, memInst = 0x00100513; ram_addr sequence 0x100..0x103; memInstFree low Tr+1..Tr+5.
- Half write: dataEn, dataWr = 1, dataLen = 01, addr 0x204, dataIn = 0x1234BEEF -> ram_wr = 1 for 2 cycles with (0x204, EF), (0x205, BE); memDataOutEn at Tr+3; RAM[0x206] untouched.
- Byte read: RAM[0x300] = 0x80; dataLen = 00 -> memData = 0x00000080 at Tr+3.
- Simultaneous requests: instEn(0x100) and dataEn read word at 0x400 = 0xDEADBEEF in the same cycle -> memDataOutEn at Tr+6 with 0xDEADBEEF; memInstOutEn at Tr+12 with 0x00100513.
- Wrap: word read at 0xFFFFFFFE -> ram_addr FFFFFFFE, FFFFFFFF, 0, 1; bytes assembled in that order.
- Reset in Tr+3 of a word write -> ram_wr = 0 from the next cycle, no memDataOutEn, both Free = 1; a new instEn afterwards completes normally.
